// File: rtl/ascon_pack.sv
// Shared Ascon constants plus the input block assembler's word/count sizes and FSM state type.
package ascon_pack;

    localparam int BLOCK_WIDTH     = 128;
    localparam int PAD_NO          = BLOCK_WIDTH / 8;
    localparam int PAD_AW          = $clog2(PAD_NO);
    localparam int WORD_WIDTH      = 32;
    localparam int WORDS_PER_BLOCK = BLOCK_WIDTH / WORD_WIDTH;
    localparam int WORD_BYTES      = WORD_WIDTH / 8;
    localparam int CNT_W           = $clog2(PAD_NO + 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        OUT     = 2'd1,
        OUT_PAD = 2'd2
    } asm_state_t;

endpackage

// File: rtl/ascon_input_pad.sv
// Ascon padding of a partial block: byte idx_i becomes 0x01 and every byte above it is zeroed.
module ascon_input_pad
    import ascon_pack::*;
(
    input  logic [BLOCK_WIDTH-1:0] blk_i,
    input  logic [PAD_AW-1:0]      idx_i,
    output logic [BLOCK_WIDTH-1:0] blk_o
);

    always_comb begin
        blk_o = blk_i;
        for (int i = 0; i < PAD_NO; i++) begin
            if (PAD_AW'(i) == idx_i) begin
                blk_o[8*i +: 8] = 8'h01;
            end else if (PAD_AW'(i) > idx_i) begin
                blk_o[8*i +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/ascon_block_assembler.sv
// Packs 32-bit words into 128-bit little-endian blocks for the Ascon absorb stage.
// Define ASCON_ASM_PAD_EN for Ascon padding; undefined gives raw zero-filled blocks (key/nonce/tag).
module ascon_block_assembler
    import ascon_pack::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wd_valid_i,
    output logic                   wd_ready_o,
    input  logic [WORD_WIDTH-1:0]  wd_data_i,
    input  logic [2:0]             wd_bytes_i,
    input  logic                   wd_last_i,
    output logic                   blk_valid_o,
    input  logic                   blk_ready_i,
    output logic [BLOCK_WIDTH-1:0] blk_data_o,
    output logic [PAD_AW-1:0]      blk_pad_idx_o,
    output logic                   blk_padded_o,
    output logic                   blk_last_o
);

    asm_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BLOCK_WIDTH-1:0] buf_q, buf_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;

    logic [2:0]             nbytes;
    logic [CNT_W-1:0]       cnt_new;
    logic [BLOCK_WIDTH-1:0] merged;
    logic                   done;
    logic                   clear;

`ifdef ASCON_ASM_PAD_EN
    logic [BLOCK_WIDTH-1:0] padded_blk;
    logic                   pad_q, pad_d;
    logic                   pend_q, pend_d;
    logic [PAD_AW-1:0]      idx_q, idx_d;

    ascon_input_pad u_pad (
        .blk_i (merged),
        .idx_i (cnt_new[PAD_AW-1:0]),
        .blk_o (padded_blk)
    );
`endif

    // Only a final word may be short, so every word lands on a word-aligned offset.
    always_comb begin
        nbytes = 3'd4;
        if (wd_last_i && (wd_bytes_i < 3'd4)) begin
            nbytes = wd_bytes_i;
        end
        cnt_new = cnt_q + CNT_W'(nbytes);
        done    = wd_last_i || (cnt_new == CNT_W'(PAD_NO));
        merged  = buf_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (3'(k) < nbytes) begin
                merged[{cnt_q[3:2], 2'(k), 3'b000} +: 8] = wd_data_i[8*k +: 8];
            end
        end
    end

    // NOTE: every _d gets a hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        last_d  = last_q;
        clear   = 1'b0;
`ifdef ASCON_ASM_PAD_EN
        pad_d   = pad_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            FILL: begin
                if (wd_valid_i) begin
                    buf_d = merged;
                    cnt_d = cnt_new;
                    if (done) begin
                        state_d = OUT;
                        valid_d = 1'b1;
`ifdef ASCON_ASM_PAD_EN
                        if (cnt_new == CNT_W'(PAD_NO)) begin
                            pend_d = wd_last_i;
                            last_d = 1'b0;
                        end else begin
                            buf_d  = padded_blk;
                            pad_d  = 1'b1;
                            idx_d  = cnt_new[PAD_AW-1:0];
                            last_d = 1'b1;
                        end
`else
                        last_d = wd_last_i;
`endif
                    end
                end
            end
            OUT: begin
                if (blk_ready_i) begin
                    clear = 1'b1;
`ifdef ASCON_ASM_PAD_EN
                    // A message that filled its last block exactly still owes a pad-only block.
                    if (pend_q) begin
                        clear   = 1'b0;
                        state_d = OUT_PAD;
                        buf_d   = BLOCK_WIDTH'(1);
                        pad_d   = 1'b1;
                        idx_d   = '0;
                        last_d  = 1'b1;
                        pend_d  = 1'b0;
                    end
`endif
                end
            end
            OUT_PAD: begin
                if (blk_ready_i) begin
                    clear = 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase

        if (clear) begin
            state_d = FILL;
            cnt_d   = '0;
            buf_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
`ifdef ASCON_ASM_PAD_EN
            pad_d   = 1'b0;
            idx_d   = '0;
            pend_d  = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef ASCON_ASM_PAD_EN
            pad_q   <= 1'b0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`ifdef ASCON_ASM_PAD_EN
            pad_q   <= pad_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign wd_ready_o  = (state_q == FILL);
    assign blk_valid_o = valid_q;
    assign blk_data_o  = buf_q;
    assign blk_last_o  = last_q;
`ifdef ASCON_ASM_PAD_EN
    assign blk_padded_o  = pad_q;
    assign blk_pad_idx_o = idx_q;
`else
    assign blk_padded_o  = 1'b0;
    assign blk_pad_idx_o = '0;
`endif

endmodule
